// File: rtl/alu_seq_pkg.sv
// Shared types for the multi-byte ALU sequencer: ALU command encodings,
// sequencer states and the request-opcode legality check.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_LSL  = 3'b001,
    ALU_LSR  = 3'b010,
    ALU_NAND = 3'b011,
    ALU_SUB  = 3'b100,
    ALU_ADD2 = 3'b111
  } alu_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } seq_state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return !((op == 3'b101) || (op == 3'b110));
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Request/response channel between the execute stage (master) and the
// multi-byte ALU sequencer (slave).
interface alu_seq_ctrl_if #(
  parameter int NBYTES = 2
);
  localparam int W = 8 * NBYTES;

  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_op;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_rslt;
  logic         rsp_carry;
  logic         rsp_zero;
  logic         rsp_pari;
  logic         rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_rslt, rsp_carry, rsp_zero, rsp_pari, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_rslt, rsp_carry, rsp_zero, rsp_pari, rsp_err
  );

endinterface

// File: rtl/alu_seq_lane_sel.sv
// Byte-lane selector: maps the byte counter to a lane (LSB- or MSB-first)
// and extracts the A and (optionally inverted) B bytes for that lane.
module alu_seq_lane_sel #(
  parameter int NBYTES = 2,
  parameter int IW     = 1
) (
  input  logic [IW-1:0]         i_idx,
  input  logic                  i_msb_first,
  input  logic                  i_inv_b,
  input  logic [8*NBYTES-1:0]   i_a,
  input  logic [8*NBYTES-1:0]   i_b,
  output logic [IW-1:0]         o_lane,
  output logic [7:0]            o_a_byte,
  output logic [7:0]            o_b_byte
);

  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  always_comb begin
    o_lane   = i_msb_first ? (LAST - i_idx) : i_idx;
    o_a_byte = i_a[o_lane*8 +: 8];
    o_b_byte = i_inv_b ? ~i_b[o_lane*8 +: 8] : i_b[o_lane*8 +: 8];
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-byte arithmetic sequencer: accepts one NBYTES-wide operation and
// issues one 8-bit ALU op per cycle, chaining carry and folding zero/parity.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int NBYTES = 2
) (
  input  logic               clk,
  input  logic               reset,
  alu_seq_ctrl_if.slave      bus,
  output logic [2:0]         alu_cmd,
  output logic [7:0]         alu_inA,
  output logic [7:0]         alu_inB,
  output logic               alu_sc_i,
  input  logic [7:0]         alu_rslt,
  input  logic               alu_sc_o,
  input  logic               alu_zero,
  input  logic               alu_pari
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  seq_state_t    r_state, w_next;
  alu_cmd_t      r_op;
  logic [W-1:0]  r_a, r_b, r_res;
  logic [IW-1:0] r_idx;
  logic          r_carry, r_zacc, r_pacc, r_err;

  logic          r_rsp_valid, r_rsp_carry, r_rsp_zero, r_rsp_pari, r_rsp_err;
  logic [W-1:0]  r_rsp_rslt;

  logic          w_accept, w_legal, w_last;
  logic [IW-1:0] w_lane;
  logic [7:0]    w_a_byte, w_b_byte;
  alu_cmd_t      w_cmd;

  assign bus.req_ready = (r_state == IDLE) & ~reset;
  assign w_accept      = bus.req_valid & bus.req_ready;
  assign w_legal       = op_legal(bus.req_op);
  assign w_last        = (r_idx == LAST);

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rslt  = r_rsp_rslt;
  assign bus.rsp_carry = r_rsp_carry;
  assign bus.rsp_zero  = r_rsp_zero;
  assign bus.rsp_pari  = r_rsp_pari;
  assign bus.rsp_err   = r_rsp_err;

  alu_seq_lane_sel #(
    .NBYTES (NBYTES),
    .IW     (IW)
  ) u_lane_sel (
    .i_idx       (r_idx),
    .i_msb_first (r_op == ALU_LSR),
    .i_inv_b     (r_op == ALU_SUB),
    .i_a         (r_a),
    .i_b         (r_b),
    .o_lane      (w_lane),
    .o_a_byte    (w_a_byte),
    .o_b_byte    (w_b_byte)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_accept) w_next = w_legal ? RUN : DONE;
      RUN:  if (w_last) w_next = DONE;
      DONE: if (r_rsp_valid && bus.rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // SUB is issued as ADD of ~B with carry-in 1; the ALU SUB code is never used.
  always_comb begin
    w_cmd    = ALU_ADD;
    alu_inA  = '0;
    alu_inB  = '0;
    alu_sc_i = 1'b0;
    if (r_state == RUN) begin
      alu_inA = w_a_byte;
      unique case (r_op)
        ALU_LSL, ALU_LSR: begin
          w_cmd    = r_op;
          alu_sc_i = r_carry;
        end
        ALU_NAND: begin
          w_cmd   = ALU_NAND;
          alu_inB = w_b_byte;
        end
        default: begin
          w_cmd    = ALU_ADD;
          alu_inB  = w_b_byte;
          alu_sc_i = r_carry;
        end
      endcase
    end
  end

  assign alu_cmd = w_cmd;

  // Response registers load on the first DONE cycle, so rsp_valid trails DONE entry by one edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op        <= ALU_ADD;
      r_a         <= '0;
      r_b         <= '0;
      r_res       <= '0;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_zacc      <= 1'b0;
      r_pacc      <= 1'b0;
      r_err       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rslt  <= '0;
      r_rsp_carry <= 1'b0;
      r_rsp_zero  <= 1'b0;
      r_rsp_pari  <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (!w_legal)                          r_op <= ALU_ADD;
            else if (bus.req_op == 3'(ALU_ADD2))   r_op <= ALU_ADD;
            else                                   r_op <= alu_cmd_t'(bus.req_op);
            r_a     <= bus.req_a;
            r_b     <= bus.req_b;
            r_res   <= '0;
            r_idx   <= '0;
            r_carry <= w_legal && (bus.req_op == 3'(ALU_SUB));
            r_zacc  <= 1'b1;
            r_pacc  <= 1'b0;
            r_err   <= ~w_legal;
          end
        end
        RUN: begin
          r_res[w_lane*8 +: 8] <= alu_rslt;
          r_carry <= (r_op == ALU_NAND) ? 1'b0 : alu_sc_o;
          r_zacc  <= r_zacc & alu_zero;
          r_pacc  <= r_pacc ^ alu_pari;
          r_idx   <= w_last ? '0 : r_idx + 1'b1;
        end
        DONE: begin
          if (!r_rsp_valid) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rslt  <= r_res;
            r_rsp_carry <= r_carry;
            r_rsp_zero  <= r_zacc;
            r_rsp_pari  <= r_pacc;
            r_rsp_err   <= r_err;
          end else if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rslt  <= '0;
            r_rsp_carry <= 1'b0;
            r_rsp_zero  <= 1'b0;
            r_rsp_pari  <= 1'b0;
            r_rsp_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
